load_store_unit: RTL and testbench

Memory-stage request initiator: it takes the pipeline's load/store command and drives a request/grant/response handshake to the data memory. It formats store data and byte enables and extracts/extends load data. It stalls the pipeline until the access completes and flags misaligned, illegal or timed-out accesses. It sits between the execute/memory pipeline register and the data memory responder.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store initiator: drives a req/gnt/rvalid handshake to data memory,
// formats store lanes and byte enables, extracts and extends load data, and stalls the pipeline.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] ld_q, ld_d;

  logic        cmd;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_fmt;
  logic [31:0] wd_fmt;
  logic [31:0] lane;
  logic [31:0] ld_ext;

  assign cmd = MemRead | MemWr;

  always_comb begin
    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
              (MemWr && funct3[2]);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    be_fmt = 4'b0000;
    wd_fmt = write_data;
    case (funct3[1:0])
      2'b00: begin
        be_fmt = 4'b0001 << addr[1:0];
        wd_fmt = {4{write_data[7:0]}};
      end
      2'b01: begin
        be_fmt = addr[1] ? 4'b1100 : 4'b0011;
        wd_fmt = {2{write_data[15:0]}};
      end
      2'b10: begin
        be_fmt = 4'b1111;
        wd_fmt = write_data;
      end
      default: begin
        be_fmt = 4'b0000;
        wd_fmt = write_data;
      end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'h000000, lane[7:0]};
      3'b101:  ld_ext = {16'h0000, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: begin
        if (cmd) begin
          we_d    = MemWr;
          f3_d    = funct3;
          addr_d  = addr;
          be_d    = be_fmt;
          wdata_d = MemWr ? wd_fmt : '0;
          cnt_d   = '0;
          if (illegal || misaligned) begin
            fault_d = 1'b1;
            state_d = DONE;
            if (!MemWr) ld_d = '0;
          end else begin
            fault_d = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 16'd1;
        // A granted store has completed; a load grant in the last budget cycle
        // would overrun the budget in WAIT, so the timeout wins there.
        if (mem_gnt && we_q) begin
          fault_d = 1'b0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          fault_d = 1'b1;
          state_d = DONE;
          if (!we_q) ld_d = '0;
        end else if (mem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_rvalid) begin
          fault_d = 1'b0;
          ld_d    = ld_ext;
          state_d = DONE;
        end else if (cnt_q >= TO_LAST) begin
          fault_d = 1'b1;
          ld_d    = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end

  assign stall     = n_rst & (((state_q == IDLE) & cmd) | (state_q == REQ) | (state_q == WAIT));
  assign done      = (state_q == DONE);
  assign fault     = (state_q == DONE) & fault_q;
  assign load_data = ld_q;
  assign mem_req   = (state_q == REQ);
  assign mem_we    = we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected memory requests and
// completions; monitors pop and compare when the DUT presents mem_req or done.
module tb_load_store_unit;

  logic        clk;
  logic        n_rst;
  logic        MemRead, MemWr;
  logic [2:0]  funct3;
  logic [31:0] addr, write_data;
  logic        stall, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .n_rst(n_rst), .MemRead(MemRead), .MemWr(MemWr), .funct3(funct3),
    .addr(addr), .write_data(write_data), .stall(stall), .done(done), .fault(fault),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        flt;
    logic [31:0] ld;
    int          lat;
    int          issue;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          resp_en   = 1'b1;
  bit          never_gnt = 1'b0;
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  logic [31:0] rdata_val = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"},     {31'b0, stall},     32'h0);
    check({tag, "_done"},      {31'b0, done},      32'h0);
    check({tag, "_fault"},     {31'b0, fault},     32'h0);
    check({tag, "_mem_req"},   {31'b0, mem_req},   32'h0);
    check({tag, "_mem_we"},    {31'b0, mem_we},    32'h0);
    check({tag, "_mem_addr"},  mem_addr,           32'h0);
    check({tag, "_mem_be"},    {28'b0, mem_be},    32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,          32'h0);
    check({tag, "_load_data"}, load_data,          32'h0);
  endtask

  // Memory responder: grant after gnt_delay req cycles, rvalid rv_delay cycles after a load grant.
  initial begin
    int gcnt = 0;
    int rcnt = 0;
    bit rpend = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5A5A5;
    forever begin
      @(posedge clk); #1;
      if (resp_en) begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hA5A5A5A5;
        if (!n_rst) begin
          gcnt = 0; rpend = 1'b0;
        end else if (mem_req) begin
          if (!never_gnt && gcnt >= gnt_delay) begin
            mem_gnt = 1'b1; gcnt = 0; rpend = !mem_we; rcnt = 0;
          end else gcnt++;
        end else begin
          gcnt = 0;
          if (rpend) begin
            if (rcnt >= rv_delay) begin
              mem_rvalid = 1'b1; mem_rdata = rdata_val; rpend = 1'b0;
            end else rcnt++;
          end
        end
      end
    end
  end

  // Request monitor: every mem_req cycle must match the head of the expected queue.
  always @(negedge clk) begin
    if (n_rst && mem_req) begin
      if (req_q.size() == 0) begin
        check("spurious_req", {31'b0, mem_req}, 32'h0);
      end else begin
        check("req_we",    {31'b0, mem_we}, {31'b0, req_q[0].we});
        check("req_addr",  mem_addr,        req_q[0].addr);
        check("req_be",    {28'b0, mem_be}, {28'b0, req_q[0].be});
        check("req_wdata", mem_wdata,       req_q[0].wdata);
        if (mem_gnt) void'(req_q.pop_front());
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (n_rst && done) begin
      if (rsp_q.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'h0);
      end else begin
        rsp_t e;
        e = rsp_q.pop_front();
        check("rsp_fault",     {31'b0, fault},   {31'b0, e.flt});
        check("rsp_load_data", load_data,        e.ld);
        check("rsp_latency",   32'(cyc - e.issue), 32'(e.lat));
        check("rsp_stall",     {31'b0, stall},   32'h0);
        check("rsp_req_low",   {31'b0, mem_req}, 32'h0);
      end
    end
  end

  task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int gd,
                        input int rvd, input bit ng, input bit exp_req, input logic [3:0] ebe,
                        input logic [31:0] ewd, input bit efault, input logic [31:0] eld,
                        input int elat);
    req_t r;
    rsp_t s;
    bit got;
    gnt_delay = gd; rv_delay = rvd; never_gnt = ng; rdata_val = rd;
    if (exp_req) begin
      r.we = wr; r.addr = {a[31:2], 2'b00}; r.be = ebe; r.wdata = ewd;
      req_q.push_back(r);
    end
    s.flt = efault; s.ld = eld; s.lat = elat; s.issue = cyc;
    rsp_q.push_back(s);
    MemWr = wr; MemRead = !wr; funct3 = f3; addr = a; write_data = wd;
    #1 check("stall_cycle0", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    MemRead = 1'b0; MemWr = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    if (!got) check("done_wait_expired", 32'h0, 32'h1);
    @(posedge clk); #1;
    if (ng && req_q.size() > 0) void'(req_q.pop_front());
    never_gnt = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; MemRead = 1'b0; MemWr = 1'b0; funct3 = '0; addr = '0; write_data = '0;
    #3 check_reset_outputs("por");
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;

    //     wr    f3      addr          wdata         rdata         gd rv ng req be       exp_wdata     flt  load_data     lat
    run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 1, 4'b1111, 32'hDEAD_BEEF, 0, 32'h0000_0000, 2);
    run_op(1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 0, 0, 1, 4'b1000, 32'h0,        0, 32'hFFFF_FF80, 3);
    run_op(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 0, 0, 0, 1, 4'b1000, 32'h0,        0, 32'h0000_0080, 3);
    run_op(1'b0, 3'b101, 32'h0000_0202, 32'h0,        32'h80FF_1234, 0, 0, 0, 1, 4'b1100, 32'h0,        0, 32'h0000_80FF, 3);
    run_op(1'b1, 3'b001, 32'h0000_0012, 32'h0000_ABCD, 32'h0,        0, 0, 0, 1, 4'b1100, 32'hABCD_ABCD, 0, 32'h0000_80FF, 2);
    run_op(1'b1, 3'b000, 32'h0000_0011, 32'hFFFF_FF5A, 32'h0,        0, 0, 0, 1, 4'b0010, 32'h5A5A_5A5A, 0, 32'h0000_80FF, 2);
    run_op(1'b0, 3'b001, 32'h0000_0202, 32'h0,        32'h80FF_1234, 1, 1, 0, 1, 4'b1100, 32'h0,        0, 32'hFFFF_80FF, 5);
    run_op(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h0000_0000, 1);
    run_op(1'b1, 3'b100, 32'h0000_0020, 32'h0000_0001, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h0000_0000, 1);
    run_op(1'b0, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 0, 0, 0, 1, 4'b1111, 32'h0,        0, 32'h1234_5678, 3);
    run_op(1'b0, 3'b010, 32'h0000_0304, 32'h0,        32'h0,        0, 0, 1, 1, 4'b1111, 32'h0,        1, 32'h0000_0000, 5);
    run_op(1'b0, 3'b010, 32'h0000_0308, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 1, 4'b1111, 32'h0,        0, 32'hCAFE_F00D, 3);
    run_op(1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'h0000_0000, 1);
    run_op(1'b0, 3'b100, 32'h0000_0400, 32'h0,        32'h0000_00F7, 0, 0, 0, 1, 4'b0001, 32'h0,        0, 32'h0000_00F7, 3);
    run_op(1'b0, 3'b000, 32'h0000_0401, 32'h0,        32'h0000_F700, 0, 0, 0, 1, 4'b0010, 32'h0,        0, 32'hFFFF_FFF7, 3);
    run_op(1'b1, 3'b010, 32'h0000_040C, 32'h0102_0304, 32'h0,        2, 0, 0, 1, 4'b1111, 32'h0102_0304, 0, 32'hFFFF_FFF7, 4);
    run_op(1'b1, 3'b001, 32'h0000_0013, 32'h0000_1111, 32'h0,        0, 0, 0, 0, 4'b0000, 32'h0,        1, 32'hFFFF_FFF7, 1);
    run_op(1'b0, 3'b010, 32'h0000_0700, 32'h0,        32'h0BAD_F00D, 0, 0, 0, 1, 4'b1111, 32'h0,        0, 32'h0BAD_F00D, 3);

    // Reset while a load waits for its response; a late rvalid afterwards must be ignored.
    begin
      req_t r;
      resp_en = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      r.we = 1'b0; r.addr = 32'h0000_0500; r.be = 4'b1111; r.wdata = '0;
      req_q.push_back(r);
      MemRead = 1'b1; funct3 = 3'b010; addr = 32'h0000_0500;
      @(posedge clk); #1;
      MemRead = 1'b0; mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      check("wait_stall", {31'b0, stall}, 32'h1);
      #2 n_rst = 1'b0;
      #1 check_reset_outputs("midop_rst");
      @(negedge clk); n_rst = 1'b1;
      @(posedge clk); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'hA5A5A5A5;
      repeat (3) @(posedge clk);
      #1;
      check("late_rvalid_ld", load_data, 32'h0);
      check("late_rvalid_stall", {31'b0, stall}, 32'h0);
      resp_en = 1'b1;
    end

    run_op(1'b0, 3'b010, 32'h0000_0600, 32'h0,        32'h1357_2468, 0, 0, 0, 1, 4'b1111, 32'h0,        0, 32'h1357_2468, 3);

    repeat (2) @(posedge clk);
    check("req_queue_empty", 32'(req_q.size()), 32'h0);
    check("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1);
  end

endmodule
